// File: rtl/enc_bundler_accum_pkg.sv
// Shared encoder definitions: HV geometry, bundler FSM states and the 10-input popcount.
package enc_bundler_accum_pkg;

  localparam int HV_DIM           = 64;
  localparam int BINDERS_PER_PACK = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    THRESH = 2'd2,
    DONE   = 2'd3
  } enc_bund_state_t;

  function automatic logic [3:0] popcount10(input logic [BINDERS_PER_PACK-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < BINDERS_PER_PACK; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/enc_bundler_accum_bit_counter.sv
// Per-dimension accumulator: adds the popcount of one bit across the 10 bound HVs each beat.
// ENC_BUNDLER_SAT_EN selects a saturating counter instead of a counter sized to never overflow.
module enc_bit_counter
  import enc_bundler_accum_pkg::*;
#(
  parameter int ACC_W = 6
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        clear,
  input  logic                        en,
  input  logic [BINDERS_PER_PACK-1:0] bits,
  output logic [ACC_W-1:0]            count
);

  logic [3:0] pop;

  assign pop = popcount10(bits);

`ifdef ENC_BUNDLER_SAT_EN
  // Sum is widened so the comparison against the ceiling sees the true total.
  localparam logic [ACC_W+4:0] SAT_MAX = (ACC_W+5)'((64'd1 << ACC_W) - 64'd1);

  logic [ACC_W+4:0] sum;

  assign sum = (ACC_W+5)'(count) + (ACC_W+5)'(pop);

  always_ff @(posedge clk) begin
    if (nrst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (sum > SAT_MAX) ? SAT_MAX[ACC_W-1:0] : sum[ACC_W-1:0];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (nrst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + ACC_W'(pop);
    end
  end
`endif

endmodule

// File: rtl/enc_bundler_accum.sv
// Bundles NUM_BEATS binder packs into one thresholded query HV with a valid/ready output.
// Build option ENC_BUNDLER_SAT_EN: saturating CNT_W-bit counters instead of overflow-free widths.
//
// state  | meaning
// IDLE   | waiting for start_encoding; clears counts on start
// ACCUM  | accepting beats, in_ready high
// THRESH | registering query_hv from the counts
// DONE   | query_hv held with out_valid until out_ready
module enc_bundler_accum
  import enc_bundler_accum_pkg::*;
#(
  parameter  int NUM_BEATS = 32,
  parameter  int CNT_W     = 6,
  parameter  int THRESHOLD = 3,
  localparam int BEAT_W    = $clog2(NUM_BEATS + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] shifted_hv [0:BINDERS_PER_PACK-1],
  output logic [HV_DIM-1:0] query_hv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] beat_cnt
);

  localparam int MIN_W = $clog2(BINDERS_PER_PACK * NUM_BEATS + 1);
`ifdef ENC_BUNDLER_SAT_EN
  localparam int ACC_W = CNT_W;
`else
  localparam int ACC_W = (CNT_W > MIN_W) ? CNT_W : MIN_W;
`endif
  localparam logic [ACC_W+4:0] THR_V = (ACC_W+5)'(THRESHOLD);

  enc_bund_state_t   state, state_nxt;
  logic              acc_clear;
  logic              acc_en;
  logic              q_load;
  logic              last_beat;
  logic [ACC_W-1:0]  counts [HV_DIM];
  logic [HV_DIM-1:0] thresh_vec;

  assign last_beat = (beat_cnt == BEAT_W'(NUM_BEATS - 1));

  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    q_load    = 1'b0;
    case (state)
      IDLE: begin
        if (start_encoding) begin
          acc_clear = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_en = 1'b1;
          if (last_beat) state_nxt = THRESH;
        end
      end
      THRESH: begin
        q_load    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      beat_cnt <= '0;
    end else if (acc_clear) begin
      beat_cnt <= '0;
    end else if (acc_en) begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
    logic [BINDERS_PER_PACK-1:0] bits;

    always_comb begin
      for (int b = 0; b < BINDERS_PER_PACK; b++) begin
        bits[b] = shifted_hv[b][d];
      end
    end

    enc_bit_counter #(.ACC_W(ACC_W)) u_bit (
      .clk   (clk),
      .nrst  (nrst),
      .clear (acc_clear),
      .en    (acc_en),
      .bits  (bits),
      .count (counts[d])
    );

    assign thresh_vec[d] = ((ACC_W+5)'(counts[d]) >= THR_V);
  end

  // query_hv keeps the last result until the next THRESH so DONE can hold it stable.
  always_ff @(posedge clk) begin
    if (nrst) begin
      query_hv <= '0;
    end else if (q_load) begin
      query_hv <= thresh_vec;
    end
  end

endmodule

// File: tb/tb_enc_bundler_accum.sv
// Directed bench: three bundler instances (2-beat, 32-beat, 4-beat/4-bit) sharing data inputs.
module tb_enc_bundler_accum;
  import enc_bundler_accum_pkg::*;

  logic              clk = 1'b0;
  logic              nrst;
  logic              in_valid;
  logic              out_ready;
  logic              start_s, start_b, start_t;
  logic [HV_DIM-1:0] shifted_hv [0:BINDERS_PER_PACK-1];

  logic              in_ready_s, out_valid_s;
  logic [HV_DIM-1:0] query_s;
  logic [1:0]        beat_cnt_s;
  logic              in_ready_b, out_valid_b;
  logic [HV_DIM-1:0] query_b;
  logic [5:0]        beat_cnt_b;
  logic              in_ready_t, out_valid_t;
  logic [HV_DIM-1:0] query_t;
  logic [2:0]        beat_cnt_t;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  enc_bundler_accum #(.NUM_BEATS(2), .CNT_W(6), .THRESHOLD(3)) u_small (
    .clk(clk), .nrst(nrst), .start_encoding(start_s), .in_valid(in_valid),
    .in_ready(in_ready_s), .shifted_hv(shifted_hv), .query_hv(query_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .beat_cnt(beat_cnt_s));

  enc_bundler_accum #(.NUM_BEATS(32), .CNT_W(6), .THRESHOLD(3)) u_big (
    .clk(clk), .nrst(nrst), .start_encoding(start_b), .in_valid(in_valid),
    .in_ready(in_ready_b), .shifted_hv(shifted_hv), .query_hv(query_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .beat_cnt(beat_cnt_b));

  enc_bundler_accum #(.NUM_BEATS(4), .CNT_W(4), .THRESHOLD(3)) u_sat (
    .clk(clk), .nrst(nrst), .start_encoding(start_t), .in_valid(in_valid),
    .in_ready(in_ready_t), .shifted_hv(shifted_hv), .query_hv(query_t),
    .out_valid(out_valid_t), .out_ready(out_ready), .beat_cnt(beat_cnt_t));

  typedef struct {
    int   d;
    int   k0;
    int   k1;
    logic exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hv();
    for (int b = 0; b < BINDERS_PER_PACK; b++) shifted_hv[b] = '0;
  endtask

  task automatic set_bit(input int n, input int d);
    for (int b = 0; b < n; b++) shifted_hv[b][d] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HV_DIM-1:0] held;
    logic [HV_DIM-1:0] exp_q;

    vecs[0] = '{d: 5,  k0: 2,  k1: 1,  exp: 1'b1};
    vecs[1] = '{d: 7,  k0: 1,  k1: 0,  exp: 1'b0};
    vecs[2] = '{d: 0,  k0: 0,  k1: 0,  exp: 1'b0};
    vecs[3] = '{d: 63, k0: 10, k1: 10, exp: 1'b1};
    vecs[4] = '{d: 12, k0: 3,  k1: 0,  exp: 1'b1};
    vecs[5] = '{d: 20, k0: 1,  k1: 1,  exp: 1'b0};
    vecs[6] = '{d: 33, k0: 0,  k1: 3,  exp: 1'b1};
    vecs[7] = '{d: 40, k0: 2,  k1: 0,  exp: 1'b0};

    nrst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    start_s = 1'b0; start_b = 1'b0; start_t = 1'b0;
    clear_hv();
    tick(); tick();
    nrst = 1'b0;
    tick();

    chk("rst_in_ready", 64'(in_ready_s), 64'(0));
    chk("rst_out_valid", 64'(out_valid_s), 64'(0));
    chk("rst_query", 64'(query_s), 64'(0));
    chk("rst_beat_cnt", 64'(beat_cnt_s), 64'(0));
    chk("rst_big_out_valid", 64'(out_valid_b), 64'(0));

    // Basic threshold with latency checks.
    start_s = 1'b1; tick(); start_s = 1'b0;
    chk("basic_accum_in_ready", 64'(in_ready_s), 64'(1));
    clear_hv(); set_bit(2, 5); shifted_hv[0][7] = 1'b1;
    in_valid = 1'b1; tick();
    chk("basic_beat1_cnt", 64'(beat_cnt_s), 64'(1));
    clear_hv(); shifted_hv[2][5] = 1'b1;
    tick();
    in_valid = 1'b0; clear_hv();
    chk("basic_thresh_in_ready", 64'(in_ready_s), 64'(0));
    chk("basic_no_valid_at_plus1", 64'(out_valid_s), 64'(0));
    tick();
    chk("basic_out_valid_at_plus2", 64'(out_valid_s), 64'(1));
    chk("basic_query", 64'(query_s), 64'(1) << 5);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("basic_valid_drops", 64'(out_valid_s), 64'(0));

    // Table-driven samples on the 2-beat instance.
    for (int i = 0; i < 8; i++) begin
      start_s = 1'b1; tick(); start_s = 1'b0;
      clear_hv(); set_bit(vecs[i].k0, vecs[i].d);
      in_valid = 1'b1; tick();
      clear_hv(); set_bit(vecs[i].k1, vecs[i].d);
      tick();
      in_valid = 1'b0; clear_hv();
      tick();
      exp_q = vecs[i].exp ? (64'(1) << vecs[i].d) : 64'(0);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid_s), 64'(1));
      chk($sformatf("vec%0d_query", i), 64'(query_s), 64'(exp_q));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end

    // Stalls: in_valid 1,0,0,1 with basic data.
    start_s = 1'b1; tick(); start_s = 1'b0;
    clear_hv(); set_bit(2, 5); shifted_hv[0][7] = 1'b1;
    in_valid = 1'b1; tick();
    chk("stall_cnt_a", 64'(beat_cnt_s), 64'(1));
    clear_hv(); set_bit(10, 9);
    in_valid = 1'b0; tick();
    chk("stall_cnt_b", 64'(beat_cnt_s), 64'(1));
    tick();
    chk("stall_cnt_c", 64'(beat_cnt_s), 64'(1));
    chk("stall_in_ready", 64'(in_ready_s), 64'(1));
    clear_hv(); shifted_hv[2][5] = 1'b1;
    in_valid = 1'b1; tick();
    chk("stall_cnt_d", 64'(beat_cnt_s), 64'(2));
    in_valid = 1'b0; clear_hv();
    tick();
    chk("stall_query", 64'(query_s), 64'(1) << 5);

    // Backpressure: hold in DONE for 5 cycles, start pulse ignored.
    held = query_s;
    for (int c = 0; c < 5; c++) begin
      start_s = (c == 2);
      chk($sformatf("bp_out_valid_%0d", c), 64'(out_valid_s), 64'(1));
      chk($sformatf("bp_query_%0d", c), 64'(query_s), 64'(held));
      chk($sformatf("bp_in_ready_%0d", c), 64'(in_ready_s), 64'(0));
      tick();
    end
    start_s = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_idle_out_valid", 64'(out_valid_s), 64'(0));
    tick();
    chk("bp_idle_no_accum", 64'(in_ready_s), 64'(0));

    // Saturation instance: bit 0 in all 10 HVs for 4 beats.
    start_t = 1'b1; tick(); start_t = 1'b0;
    clear_hv(); set_bit(10, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0; clear_hv();
    tick();
    chk("sat_out_valid", 64'(out_valid_t), 64'(1));
    chk("sat_query0", 64'(query_t), 64'(1));
`ifdef ENC_BUNDLER_SAT_EN
    chk("sat_count", 64'(u_sat.g_dim[0].u_bit.count), 64'(15));
`else
    chk("sat_count", 64'(u_sat.g_dim[0].u_bit.count), 64'(40));
`endif
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Mid-sample reset on the 32-beat instance.
    start_b = 1'b1; tick(); start_b = 1'b0;
    clear_hv(); set_bit(10, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("abort_cnt_before", 64'(beat_cnt_b), 64'(3));
    nrst = 1'b1; tick(); nrst = 1'b0;
    chk("abort_beat_cnt", 64'(beat_cnt_b), 64'(0));
    chk("abort_in_ready", 64'(in_ready_b), 64'(0));
    chk("abort_out_valid", 64'(out_valid_b), 64'(0));
    in_valid = 1'b0; clear_hv();
    nrst = 1'b1; start_b = 1'b1; tick(); nrst = 1'b0; start_b = 1'b0;
    chk("rst_over_start", 64'(in_ready_b), 64'(0));

    // Full sample with a stray start during beat 10.
    start_b = 1'b1; tick(); start_b = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      clear_hv();
      if (i < 3) shifted_hv[0][2] = 1'b1;
      if (i == 5) shifted_hv[0][1] = 1'b1;
      start_b = (i == 10);
      tick();
      if (i == 10) begin
        chk("start_in_accum_cnt", 64'(beat_cnt_b), 64'(11));
        chk("start_in_accum_ready", 64'(in_ready_b), 64'(1));
      end
    end
    start_b = 1'b0; in_valid = 1'b0; clear_hv();
    chk("big_beat_cnt", 64'(beat_cnt_b), 64'(32));
    chk("big_thresh_no_valid", 64'(out_valid_b), 64'(0));
    tick();
    chk("big_out_valid", 64'(out_valid_b), 64'(1));
    chk("big_query", 64'(query_b), 64'(1) << 2);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("big_valid_drops", 64'(out_valid_b), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/enc_bundler_accum.md
# enc_bundler_accum

Downstream stage of the encoder binder packs. Consumes ten shifted (bound) hypervectors per beat, one beat per binder pack, and keeps a per-dimension popcount across all beats of one sample. Once the last beat arrives it thresholds the counts into a single sparse query hypervector and holds it under a valid/ready handshake for the classifier.

## Interface
Parameters:
- NUM_BEATS, 32: beats (binder packs of 10 HVs) per sample.
- CNT_W, 6: per-dimension counter width.
- THRESHOLD, 3: output bit d is 1 when count[d] ≥ THRESHOLD.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- nrst  in  1  reset, synchronous, active-high.
- start_encoding  in  1  begin a new sample; honoured only in IDLE.
- in_valid  in  1  beat present on shifted_hv.
- in_ready  out  1  beat accepted this cycle when in_valid && in_ready.
- shifted_hv  in  [HV_DIM-1:0] ×10 ([0:9])  bound HVs from one binder pack.
- query_hv  out  HV_DIM  thresholded sparse HV.
- out_valid  out  1  query_hv is valid.
- out_ready  in  1  consumer takes query_hv.
- beat_cnt  out  $clog2(NUM_BEATS+1)  beats accepted in the current sample (debug).

## Operation
- FSM states: IDLE, ACCUM, THRESH, DONE.
- **IDLE:** start_encoding clears every count[d] and beat_cnt, then the FSM moves to ACCUM.
- **ACCUM:** in_ready=1. For each accepted beat:
  - count[d] += popcount of bit d across the 10 HVs (0..10).
  - beat_cnt += 1.
  - When beat_cnt reaches NUM_BEATS the FSM moves to THRESH. The last beat is counted before the transition.
- **THRESH:** query_hv[d] = (count[d] ≥ THRESHOLD) is registered, then the FSM moves to DONE.
- **DONE:** out_valid=1 and query_hv is held stable until out_ready=1. On that cycle the FSM moves to IDLE and out_valid drops on the next cycle.
- start_encoding outside IDLE is ignored. It does not restart the sample.
- in_ready=0 outside ACCUM. in_valid there is ignored and produces no counting.
- in_valid low in ACCUM is a stall: counts and beat_cnt hold.
- Arithmetic: the popcount is a 4-bit unsigned value, zero-extended to CNT_W before the add. Overflow behaviour is set by the macro below.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, query_hv=0, beat_cnt=0, all counts=0.
- nrst mid-sample aborts the sample; the next cycle is IDLE with everything cleared.
- nrst overrides start_encoding in the same cycle.
- start_encoding at cycle t: ACCUM and in_ready=1 at t+1.
- Beat accepted at t: count updated at t+1.
- Last beat accepted at t: state=THRESH at t+1; out_valid=1 and query_hv valid at t+2.
- Minimum sample period: NUM_BEATS + 3 cycles with in_valid held high and out_ready high.
- out_ready high on the first DONE cycle: out_valid is high for exactly one cycle.
- No new start_encoding is accepted until the cycle after the DONE → IDLE transition.

## Configuration
- **ENC_BUNDLER_SAT_EN defined:** count[d] saturates at 2^CNT_W−1 and never wraps. CNT_W is used as given.
- **ENC_BUNDLER_SAT_EN undefined:** no saturation logic. The counter width is max(CNT_W, $clog2(10·NUM_BEATS+1)), so overflow is impossible by construction.
- In both cases the THRESHOLD comparison is unchanged.

## Structure
- The shared encoder package holds:
  - HV_DIM (already present);
  - BINDERS_PER_PACK=10;
  - the FSM state enum typedef enc_bund_state_t.
- Sub-module enc_bit_counter, instantiated per dimension via generate. It contains the 10-input popcount, the accumulator, and the saturation option.
- The top level holds the FSM, beat counter, handshake, and the threshold register.

## Test plan
- **Basic threshold:** NUM_BEATS=2, THRESHOLD=3. Beat 1 has bit 5 set in HVs 0,1; beat 2 has bit 5 set in HV 2; bit 7 set only in HV 0 of beat 1. Required: query_hv[5]=1, query_hv[7]=0, out_valid at last-beat+2.
- **Stalls:** in_valid toggles 1,0,0,1 during ACCUM. Required: beat_cnt increments only on high cycles; result identical to the no-stall run.
- **Backpressure:** out_ready held low for 5 cycles in DONE. Required: out_valid and query_hv stable for all 5 cycles; in_ready=0; start_encoding ignored; IDLE after out_ready rises.
- **Saturation:** CNT_W=4, NUM_BEATS=4, bit 0 set in all 10 HVs every beat.
  - With ENC_BUNDLER_SAT_EN: count=15.
  - Without it: count=40.
  - Both: query_hv[0]=1.
- **Mid-sample reset:** nrst pulsed after 3 of 32 beats. Required: next cycle IDLE, beat_cnt=0, out_valid=0. A following full sample gives a result independent of the aborted beats.
- **Start in ACCUM:** start_encoding pulsed during beat 10. Required: no clear; sample completes normally after 32 beats.
